vga_frame_reader: RTL and testbench

Downstream consumer of the image BRAM filled by the UART loader. Generates 640x480@60 VGA timing and reads the stored 160x120 RGB332 image through the BRAM's second (read) port. Each stored pixel is replicated 4x horizontally and 4x vertically. Drives the VGA connector pins directly.

---
 rtl/vga_pkg.sv | 60 ++++++
 rtl/vga_frame_reader_if.sv | 36 +++
 rtl/vga_timing.sv | 38 +++
 rtl/vga_frame_reader.sv | 128 ++++++++++++
 tb/tb_vga_frame_reader.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, stored-image geometry and RGB332 colour expansion
// for the VGA frame reader and any future overlay blocks.
package vga_pkg;

    localparam int ADDR_W      = 16;
    localparam int H_CNT_W     = 10;
    localparam int V_CNT_W     = 10;
    localparam int SCALE_SHIFT = 2;

    typedef logic [H_CNT_W-1:0] hcnt_t;
    typedef logic [V_CNT_W-1:0] vcnt_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam hcnt_t H_ACTIVE = 10'd640;
    localparam hcnt_t H_FP     = 10'd16;
    localparam hcnt_t H_SYNC   = 10'd96;
    localparam hcnt_t H_BP     = 10'd48;
    localparam hcnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam hcnt_t H_LAST   = H_TOTAL - 10'd1;
    localparam hcnt_t H_SYNC_START = H_ACTIVE + H_FP;
    localparam hcnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam vcnt_t V_ACTIVE = 10'd480;
    localparam vcnt_t V_FP     = 10'd10;
    localparam vcnt_t V_SYNC   = 10'd2;
    localparam vcnt_t V_BP     = 10'd33;
    localparam vcnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam vcnt_t V_LAST   = V_TOTAL - 10'd1;
    localparam vcnt_t V_SYNC_START = V_ACTIVE + V_FP;
    localparam vcnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam addr_t IMG_W = 16'd160;
    localparam addr_t IMG_H = 16'd120;
    // row_base stops at the start of the last stored row so blanking never reads past the image
    localparam addr_t ROW_BASE_LAST = IMG_W * (IMG_H - 16'd1);

    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t rgb332_to_444(input logic [7:0] px);
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        r3 = px[R_HI:R_LO];
        g3 = px[G_HI:G_LO];
        b2 = px[B_HI:B_LO];
        return '{r: {r3, r3[2]}, g: {g3, g3[2]}, b: {b2, b2}};
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame reader bus: BRAM read port plus the VGA connector pins.
interface vga_frame_reader_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_q;
    logic              vga_hs;
    logic              vga_vs;
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              frame_start;

    modport master (
        output bram_addr,
        input  bram_q,
        output vga_hs,
        output vga_vs,
        output vga_r,
        output vga_g,
        output vga_b,
        output frame_start
    );

    modport slave (
        input  bram_addr,
        output bram_q,
        input  vga_hs,
        input  vga_vs,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster counters advancing on pix_ce, with combinational sync/active flags
// decoded from the current counter position.
module vga_timing
    import vga_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  pix_ce,
    output hcnt_t h_cnt,
    output vcnt_t v_cnt,
    output logic  active,
    output logic  hs,
    output logic  vs,
    output logic  line_end,
    output logic  frame_end
);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign active    = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign hs        = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign vs        = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));

endmodule

// File: rtl/vga_frame_reader.sv
// Reads a 160x120 RGB332 image from BRAM and scans it out 4x-replicated as 640x480@60 VGA.
// Three pix_ce-gated stages: address issue, BRAM capture, registered pin drive.
module vga_frame_reader
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pix_ce,
    input  logic show,
    vga_frame_reader_if.master bus
);

    hcnt_t   h_cnt;
    vcnt_t   v_cnt;
    logic    active;
    logic    hs;
    logic    vs;
    logic    line_end;
    logic    frame_end;
    addr_t   row_base;

    logic    vld_p0;
    logic    hs_p0;
    logic    vs_p0;
    logic    fs_p0;

    logic    vld_p1;
    logic    hs_p1;
    logic    vs_p1;
    logic    fs_p1;
    logic [7:0] q_p1;
    rgb444_t rgb_p1;

    vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active),
        .hs        (hs),
        .vs        (vs),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Every 4th active line moves to the next stored row; the add replaces a v*IMG_W multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (pix_ce && line_end) begin
            if (frame_end) begin
                row_base <= '0;
            end else if ((v_cnt < V_ACTIVE) && (v_cnt[SCALE_SHIFT-1:0] == '1) &&
                         (row_base != ROW_BASE_LAST)) begin
                row_base <= row_base + IMG_W;
            end
        end
    end

    // Stage 0: issue BRAM address, register timing flags for the same pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bram_addr <= '0;
            vld_p0        <= 1'b0;
            hs_p0         <= 1'b1;
            vs_p0         <= 1'b1;
            fs_p0         <= 1'b0;
        end else if (pix_ce) begin
            bus.bram_addr <= active ? row_base + ADDR_W'(h_cnt >> SCALE_SHIFT) : row_base;
            vld_p0        <= active;
            hs_p0         <= hs;
            vs_p0         <= vs;
            fs_p0         <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Stage 1: BRAM data has settled; capture it with the flags of its address
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            fs_p1  <= 1'b0;
        end else if (pix_ce) begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            fs_p1  <= fs_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_ce) begin
            q_p1 <= bus.bram_q;
        end
    end

    assign rgb_p1 = rgb332_to_444(q_p1);

    // Stage 2: drive connector pins; show gates colour here so blanking applies at once
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.vga_r       <= 4'd0;
            bus.vga_g       <= 4'd0;
            bus.vga_b       <= 4'd0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= pix_ce && fs_p1;
            if (pix_ce) begin
                bus.vga_hs <= hs_p1;
                bus.vga_vs <= vs_p1;
                if (vld_p1 && show) begin
                    bus.vga_r <= rgb_p1.r;
                    bus.vga_g <= rgb_p1.g;
                    bus.vga_b <= rgb_p1.b;
                end else begin
                    bus.vga_r <= 4'd0;
                    bus.vga_g <= 4'd0;
                    bus.vga_b <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: colour table, blanking, random image/show/pix_ce
// gaps against a pixel-index reference model, plus stall and mid-frame reset sequences.
module tb_vga_frame_reader;

    localparam int HA = 640, HT = 800, HS0 = 656, HS1 = 752;
    localparam int VA = 480, VT = 525, VS0 = 490, VS1 = 492;
    localparam int IW = 160, MEM_N = 19200;

    typedef struct {
        logic [7:0] px;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic pix_ce;
    logic show;

    logic [7:0] mem [0:MEM_N-1];

    int nchk = 0;
    int nerr = 0;
    int pc   = 0;
    logic last_show = 1'b0;

    vga_frame_reader_if bus();

    vga_frame_reader dut (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .show   (show),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // BRAM port B, read latency 1 clk
    always @(posedge clk) begin
        if (bus.bram_addr < 16'(MEM_N)) bus.bram_q <= mem[bus.bram_addr];
        else                            bus.bram_q <= 8'h00;
    end

    function automatic logic [11:0] exp444(input logic [7:0] px);
        int r3, g3, b2, r4, g4, b4;
        r3 = int'(px) / 32;
        g3 = (int'(px) / 4) % 8;
        b2 = int'(px) % 4;
        r4 = r3 * 2 + r3 / 4;
        g4 = g3 * 2 + g3 / 4;
        b4 = b2 * 5;
        return 12'(r4 * 256 + g4 * 16 + b4);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @%0t pc=%0d: got %0h expected %0h", nm, $time, pc, act, exp);
        end
    endtask

    // Expected state after pc pixel enables since reset: address issued for pixel pc-1,
    // pins showing pixel pc-3.
    task automatic check_model(input logic ce_edge);
        int p, h, v, ea;
        int ehs, evs, efs;
        logic [11:0] ergb;
        ea = 0;
        if (pc >= 1) begin
            p = pc - 1;
            h = p % HT;
            v = (p / HT) % VT;
            if (h < HA && v < VA) ea = (v / 4) * IW + h / 4;
            else                  ea = ((v < VA) ? v / 4 : 119) * IW;
        end
        ehs = 1; evs = 1; efs = 0; ergb = 12'h000;
        if (pc >= 3) begin
            p = pc - 3;
            h = p % HT;
            v = (p / HT) % VT;
            ehs = (h >= HS0 && h < HS1) ? 0 : 1;
            evs = (v >= VS0 && v < VS1) ? 0 : 1;
            if (h < HA && v < VA && last_show) ergb = exp444(mem[(v / 4) * IW + h / 4]);
            efs = (ce_edge && (p % (HT * VT) == 0)) ? 1 : 0;
        end
        chk("addr", int'(bus.bram_addr), ea);
        chk("hs", int'(bus.vga_hs), ehs);
        chk("vs", int'(bus.vga_vs), evs);
        chk("rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), int'(ergb));
        chk("frame_start", int'(bus.frame_start), efs);
    endtask

    task automatic clk_cycle(input logic ce, input logic r);
        pix_ce = ce;
        rst    = r;
        @(posedge clk);
        #1;
        if (r) begin
            pc = 0;
            last_show = 1'b0;
        end else if (ce) begin
            pc++;
            last_show = show;
        end
        check_model(ce && !r);
    endtask

    task automatic pix_step(input int gap);
        repeat (gap - 1) clk_cycle(1'b0, 1'b0);
        clk_cycle(1'b1, 1'b0);
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{px: 8'hE0, r: 4'hF, g: 4'h0, b: 4'h0};
        tbl[1] = '{px: 8'h1C, r: 4'h0, g: 4'hF, b: 4'h0};
        tbl[2] = '{px: 8'hFF, r: 4'hF, g: 4'hF, b: 4'hF};
        tbl[3] = '{px: 8'h03, r: 4'h0, g: 4'h0, b: 4'hF};
        tbl[4] = '{px: 8'h00, r: 4'h0, g: 4'h0, b: 4'h0};
        tbl[5] = '{px: 8'h92, r: 4'h9, g: 4'h9, b: 4'hA};
        tbl[6] = '{px: 8'h49, r: 4'h4, g: 4'h4, b: 4'h5};
        tbl[7] = '{px: 8'h6D, r: 4'h6, g: 4'h6, b: 4'h5};

        for (int i = 0; i < MEM_N; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = tbl[i].px;
        show   = 1'b1;
        pix_ce = 1'b0;
        rst    = 1'b1;

        // reset values, including pix_ce asserted during reset
        clk_cycle(1'b0, 1'b1);
        clk_cycle(1'b1, 1'b1);
        chk("reset_hs", int'(bus.vga_hs), 1);
        chk("reset_vs", int'(bus.vga_vs), 1);
        chk("reset_addr", int'(bus.bram_addr), 0);

        // colour table: stored pixel i covers output pixels 4i..4i+3 of line 0
        pix_step(4);
        pix_step(4);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                pix_step(4);
                chk("tbl_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}),
                    int'({tbl[i].r, tbl[i].g, tbl[i].b}));
                if (i == 0 && j == 0) chk("tbl_frame_start", int'(bus.frame_start), 1);
            end
        end

        // all-white image: blanking must stay black; show dropped mid-line 1
        for (int i = 0; i < MEM_N; i++) mem[i] = 8'hFF;
        clk_cycle(1'b0, 1'b1);
        for (int n = 0; n < 1900; n++) begin
            if (n == 900) show = 1'b0;
            if (n == 960) show = 1'b1;
            pix_step(4);
            if (n == 900) begin
                chk("show_off_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
                chk("show_off_hs", int'(bus.vga_hs), 1);
                chk("show_off_vs", int'(bus.vga_vs), 1);
            end
        end

        // random image, random show, random pix_ce spacing, stall and mid-frame reset
        for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
        clk_cycle(1'b0, 1'b1);
        for (int n = 0; n < 12000; n++) begin
            if ($urandom_range(63) == 0) show = ~show;
            pix_step($urandom_range(4, 2));
            if (n == 4400) repeat (50) clk_cycle(1'b0, 1'b0);
            if (n == 8300) begin
                clk_cycle(1'b1, 1'b1);
                chk("midrst_hs", int'(bus.vga_hs), 1);
                chk("midrst_vs", int'(bus.vga_vs), 1);
                chk("midrst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
                chk("midrst_addr", int'(bus.bram_addr), 0);
                pix_step(4);
                pix_step(4);
                pix_step(4);
                chk("midrst_frame_start", int'(bus.frame_start), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
